// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared field widths, lane/trace records and exception codes for the writeback stage
package wb_pkg;
  localparam int PC_W       = 32;
  localparam int DATA_W     = 32;
  localparam int REG_W      = 5;
  localparam int ECODE_W    = 8;
  localparam int CSR_ADDR_W = 14;

  localparam logic [ECODE_W-1:0] ECODE_ADE = 8'h08;
  localparam logic [ECODE_W-1:0] ECODE_ALE = 8'h09;
  localparam logic [ECODE_W-1:0] ECODE_SYS = 8'h0B;
  localparam logic [ECODE_W-1:0] ECODE_BRK = 8'h0C;
  localparam logic [ECODE_W-1:0] ECODE_INE = 8'h0D;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [REG_W-1:0]  wnum;
    logic [DATA_W-1:0] wdata;
  } trace_t;

  typedef struct packed {
    logic                v;
    logic [PC_W-1:0]     pc;
    logic [DATA_W-1:0]   result;
    logic                gr_we;
    logic [REG_W-1:0]    dest;
    logic                ex;
    logic [ECODE_W-1:0]  ecode;
    logic                esubcode;
    logic [PC_W-1:0]     vaddr;
  } lane_t;

  typedef struct packed {
    logic                  we;
    logic [CSR_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     wmask;
    logic [DATA_W-1:0]     wdata;
  } csr_t;
endpackage

// File: rtl/wb_stage_multi_if.sv
// rtl/wb_stage_multi_if.sv - memory-to-writeback bundle handshake
interface wb_stage_multi_if #(parameter int NLANE = 2);
  import wb_pkg::*;

  logic                     mw_valid;
  logic                     w_allowin;
  logic [NLANE-1:0]         mw_lane_v;
  logic [PC_W*NLANE-1:0]    mw_pc;
  logic [DATA_W*NLANE-1:0]  mw_result;
  logic [NLANE-1:0]         mw_gr_we;
  logic [REG_W*NLANE-1:0]   mw_dest;
  logic [NLANE-1:0]         mw_ex;
  logic [ECODE_W*NLANE-1:0] mw_ecode;
  logic [NLANE-1:0]         mw_esubcode;
  logic [PC_W*NLANE-1:0]    mw_vaddr;
  logic                     mw_csr_we;
  logic [CSR_ADDR_W-1:0]    mw_csr_addr;
  logic [DATA_W-1:0]        mw_csr_wmask;
  logic [DATA_W-1:0]        mw_csr_wdata;

  modport master (
    output mw_valid, mw_lane_v, mw_pc, mw_result, mw_gr_we, mw_dest, mw_ex, mw_ecode,
           mw_esubcode, mw_vaddr, mw_csr_we, mw_csr_addr, mw_csr_wmask, mw_csr_wdata,
    input  w_allowin
  );

  modport slave (
    input  mw_valid, mw_lane_v, mw_pc, mw_result, mw_gr_we, mw_dest, mw_ex, mw_ecode,
           mw_esubcode, mw_vaddr, mw_csr_we, mw_csr_addr, mw_csr_wmask, mw_csr_wdata,
    output w_allowin
  );
endinterface

// File: rtl/wb_trace_fifo.sv
// rtl/wb_trace_fifo.sv - multi-push, single-pop circular trace buffer; pops every cycle it is non-empty
module wb_trace_fifo
  import wb_pkg::*;
#(
  parameter int NLANE = 2,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [NLANE-1:0] push_v,
  input  trace_t           push_data [NLANE],
  output trace_t           head,
  output logic             empty,
  output logic [CW-1:0]    free
);
  trace_t        mem_q [DEPTH];
  trace_t        mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pop;

  assign empty = (cnt_q == '0);
  assign free  = CW'(DEPTH) - cnt_q;
  assign head  = mem_q[rd_q];
  assign pop   = !empty;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q + AW'(pop);
    cnt_d = cnt_q - CW'(pop);
    // Active lanes pack into consecutive slots in lane order; idle lanes leave no hole.
    for (int i = 0; i < NLANE; i++) begin
      if (push_v[i]) begin
        mem_d[wr_d] = push_data[i];
        wr_d        = wr_d + AW'(1);
        cnt_d       = cnt_d + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/wb_stage_multi.sv
// rtl/wb_stage_multi.sv - NLANE-wide in-order writeback: oldest-exception commit, retire count, trace port
module wb_stage_multi
  import wb_pkg::*;
#(
  parameter int NLANE     = 2,
  parameter int DBG_DEPTH = 8,
  parameter int CNT_W     = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    flush,
  wb_stage_multi_if.slave         mw,
  output logic [NLANE-1:0]        rf_we,
  output logic [REG_W*NLANE-1:0]  rf_waddr,
  output logic [DATA_W*NLANE-1:0] rf_wdata,
  output logic                    ex_valid,
  output logic [ECODE_W-1:0]      ex_ecode,
  output logic                    ex_esubcode,
  output logic [PC_W-1:0]         ex_pc,
  output logic [PC_W-1:0]         ex_vaddr,
  output logic                    csr_we,
  output logic [CSR_ADDR_W-1:0]   csr_addr,
  output logic [DATA_W-1:0]       csr_wmask,
  output logic [DATA_W-1:0]       csr_wdata,
  output logic [CNT_W-1:0]        retire_cnt,
  output logic [PC_W-1:0]         debug_wb_pc,
  output logic [3:0]              debug_wb_rf_we,
  output logic [REG_W-1:0]        debug_wb_rf_wnum,
  output logic [DATA_W-1:0]       debug_wb_rf_wdata
);
  localparam int CW = $clog2(DBG_DEPTH) + 1;
  localparam int KW = $clog2(NLANE + 1);

  lane_t            lane_q [NLANE];
  lane_t            lane_d [NLANE];
  csr_t             csr_q, csr_d;
  logic             w_valid_q, w_valid_d;
  logic [CNT_W-1:0] retire_q, retire_d;
  trace_t           dbg_q, dbg_d;
  logic             dbg_we_q, dbg_we_d;

  logic [CW-1:0]    fifo_free;
  logic             fifo_empty;
  trace_t           fifo_head;
  trace_t           push_data [NLANE];
  logic [NLANE-1:0] push_v;
  logic             ready_go, w_allowin, load, commit;
  logic [KW-1:0]    k, n_retire;

  // Stall until the whole bundle's trace entries are guaranteed a slot.
  assign ready_go     = fifo_free >= CW'(NLANE);
  assign w_allowin    = !w_valid_q || ready_go;
  assign mw.w_allowin = w_allowin;
  assign load         = mw.mw_valid && w_allowin;
  assign commit       = rstn && w_valid_q && ready_go && !flush;

  always_comb begin
    k = KW'(NLANE);
    for (int i = NLANE - 1; i >= 0; i--)
      if (lane_q[i].v && lane_q[i].ex) k = KW'(i);
  end

  always_comb begin
    rf_we       = '0;
    rf_waddr    = '0;
    rf_wdata    = '0;
    n_retire    = '0;
    ex_ecode    = '0;
    ex_esubcode = 1'b0;
    ex_pc       = '0;
    ex_vaddr    = '0;
    for (int i = 0; i < NLANE; i++) begin
      rf_waddr[REG_W*i +: REG_W]   = lane_q[i].dest;
      rf_wdata[DATA_W*i +: DATA_W] = lane_q[i].result;
      push_data[i] = '{pc: lane_q[i].pc, wnum: lane_q[i].dest, wdata: lane_q[i].result};
      if (commit && KW'(i) < k) begin
        rf_we[i] = lane_q[i].v && lane_q[i].gr_we;
        n_retire = n_retire + KW'(lane_q[i].v);
      end
      if (KW'(i) == k) begin
        ex_ecode    = lane_q[i].ecode;
        ex_esubcode = lane_q[i].esubcode;
        ex_pc       = lane_q[i].pc;
        ex_vaddr    = lane_q[i].vaddr;
      end
    end
    push_v   = rf_we;
    ex_valid = commit && (k != KW'(NLANE));
    csr_we   = commit && lane_q[0].v && csr_q.we && (k != '0);
  end

  always_comb begin
    lane_d    = lane_q;
    csr_d     = csr_q;
    w_valid_d = w_valid_q;
    retire_d  = commit ? retire_q + CNT_W'(n_retire) : retire_q;
    if (flush) begin
      w_valid_d = 1'b0;
    end else if (load) begin
      w_valid_d = 1'b1;
      for (int i = 0; i < NLANE; i++) begin
        lane_d[i] = '{v:        mw.mw_lane_v[i],
                      pc:       mw.mw_pc[PC_W*i +: PC_W],
                      result:   mw.mw_result[DATA_W*i +: DATA_W],
                      gr_we:    mw.mw_gr_we[i],
                      dest:     mw.mw_dest[REG_W*i +: REG_W],
                      ex:       mw.mw_ex[i],
                      ecode:    mw.mw_ecode[ECODE_W*i +: ECODE_W],
                      esubcode: mw.mw_esubcode[i],
                      vaddr:    mw.mw_vaddr[PC_W*i +: PC_W]};
      end
      csr_d = '{we: mw.mw_csr_we, addr: mw.mw_csr_addr, wmask: mw.mw_csr_wmask, wdata: mw.mw_csr_wdata};
    end else if (commit) begin
      w_valid_d = 1'b0;
    end
    dbg_we_d = !fifo_empty;
    dbg_d    = fifo_empty ? dbg_q : fifo_head;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < NLANE; i++) lane_q[i] <= '0;
      csr_q     <= '0;
      w_valid_q <= 1'b0;
      retire_q  <= '0;
      dbg_q     <= '0;
      dbg_we_q  <= 1'b0;
    end else begin
      lane_q    <= lane_d;
      csr_q     <= csr_d;
      w_valid_q <= w_valid_d;
      retire_q  <= retire_d;
      dbg_q     <= dbg_d;
      dbg_we_q  <= dbg_we_d;
    end
  end

  wb_trace_fifo #(.NLANE(NLANE), .DEPTH(DBG_DEPTH)) u_trace_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push_v    (push_v),
    .push_data (push_data),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .free      (fifo_free)
  );

  assign csr_addr          = csr_q.addr;
  assign csr_wmask         = csr_q.wmask;
  assign csr_wdata         = csr_q.wdata;
  assign retire_cnt        = retire_q;
  assign debug_wb_pc       = dbg_q.pc;
  assign debug_wb_rf_we    = {4{dbg_we_q}};
  assign debug_wb_rf_wnum  = dbg_q.wnum;
  assign debug_wb_rf_wdata = dbg_q.wdata;
endmodule

// File: tb/tb_wb_stage_multi.sv
// tb/tb_wb_stage_multi.sv - directed and random bench for wb_stage_multi against a queue-based reference model
module tb_wb_stage_multi;
  import wb_pkg::*;

  localparam int NLANE   = 2;
  localparam int DEPTH   = 8;
  localparam int CNT_W   = 6;
  localparam int CNT_MOD = 1 << CNT_W;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic flush = 1'b0;

  logic [NLANE-1:0]        rf_we;
  logic [REG_W*NLANE-1:0]  rf_waddr;
  logic [DATA_W*NLANE-1:0] rf_wdata;
  logic                    ex_valid, ex_esubcode, csr_we;
  logic [ECODE_W-1:0]      ex_ecode;
  logic [31:0]             ex_pc, ex_vaddr, csr_wmask, csr_wdata, debug_wb_pc, debug_wb_rf_wdata;
  logic [CSR_ADDR_W-1:0]   csr_addr;
  logic [CNT_W-1:0]        retire_cnt;
  logic [3:0]              debug_wb_rf_we;
  logic [4:0]              debug_wb_rf_wnum;

  wb_stage_multi_if #(.NLANE(NLANE)) mw_if ();

  wb_stage_multi #(.NLANE(NLANE), .DBG_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .mw(mw_if),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .ex_valid(ex_valid), .ex_ecode(ex_ecode), .ex_esubcode(ex_esubcode), .ex_pc(ex_pc), .ex_vaddr(ex_vaddr),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wmask(csr_wmask), .csr_wdata(csr_wdata),
    .retire_cnt(retire_cnt), .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the held bundle, the trace queue, the trace output register and the retire count.
  logic             m_wv;
  logic [NLANE-1:0] m_v, m_we, m_ex, m_esub;
  logic [31:0]      m_pc [NLANE];
  logic [31:0]      m_res [NLANE];
  logic [31:0]      m_vaddr [NLANE];
  logic [4:0]       m_dest [NLANE];
  logic [7:0]       m_ecode [NLANE];
  logic             m_csr_we;
  logic [13:0]      m_csr_addr;
  logic [31:0]      m_csr_wmask, m_csr_wdata;
  trace_t           m_fifo [$];
  logic             m_dbg_v;
  trace_t           m_dbg;
  int               m_retire;
  logic             last_load;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic reset_model();
    m_wv = 1'b0; m_v = '0; m_we = '0; m_ex = '0; m_esub = '0;
    for (int i = 0; i < NLANE; i++) begin
      m_pc[i] = '0; m_res[i] = '0; m_vaddr[i] = '0; m_dest[i] = '0; m_ecode[i] = '0;
    end
    m_csr_we = 1'b0; m_csr_addr = '0; m_csr_wmask = '0; m_csr_wdata = '0;
    m_fifo.delete();
    m_dbg_v = 1'b0; m_dbg = '0; m_retire = 0; last_load = 1'b0;
  endtask

  task automatic set_lane(input int i, input logic v, input logic [31:0] pc, input logic we,
                          input logic [4:0] dest, input logic [31:0] res, input logic ex, input logic [7:0] ec);
    mw_if.mw_lane_v[i]           = v;
    mw_if.mw_pc[32*i +: 32]      = pc;
    mw_if.mw_gr_we[i]            = we;
    mw_if.mw_dest[5*i +: 5]      = dest;
    mw_if.mw_result[32*i +: 32]  = res;
    mw_if.mw_ex[i]               = ex;
    mw_if.mw_ecode[8*i +: 8]     = ec;
    mw_if.mw_esubcode[i]         = ec[0];
    mw_if.mw_vaddr[32*i +: 32]   = pc ^ 32'h5a5a_0000;
  endtask

  task automatic set_csr(input logic we, input logic [13:0] addr, input logic [31:0] mask, input logic [31:0] data);
    mw_if.mw_csr_we = we; mw_if.mw_csr_addr = addr; mw_if.mw_csr_wmask = mask; mw_if.mw_csr_wdata = data;
  endtask

  // One clock: check outputs at the falling edge, then advance the model across the rising edge.
  task automatic cycle();
    int k, nret;
    logic rg, allow, commit, load, exp_csr;
    logic [NLANE-1:0] exp_we;
    @(negedge clk);
    rg     = (DEPTH - m_fifo.size()) >= NLANE;
    allow  = !m_wv || rg;
    commit = rstn && m_wv && rg && !flush;
    load   = mw_if.mw_valid && allow;
    k = NLANE;
    for (int i = NLANE - 1; i >= 0; i--) if (m_v[i] && m_ex[i]) k = i;
    exp_we = '0; nret = 0;
    if (commit) for (int i = 0; i < k; i++) begin
      if (m_v[i]) nret++;
      exp_we[i] = m_v[i] && m_we[i];
    end
    exp_csr = commit && m_v[0] && m_csr_we && (k != 0);
    check("w_allowin", mw_if.w_allowin, allow);
    check("rf_we", rf_we, exp_we);
    for (int i = 0; i < NLANE; i++) if (exp_we[i]) begin
      check("rf_waddr", rf_waddr[5*i +: 5], m_dest[i]);
      check("rf_wdata", rf_wdata[32*i +: 32], m_res[i]);
    end
    check("ex_valid", ex_valid, commit && (k < NLANE));
    if (commit && k < NLANE) begin
      check("ex_ecode", ex_ecode, m_ecode[k]);
      check("ex_esubcode", ex_esubcode, m_esub[k]);
      check("ex_pc", ex_pc, m_pc[k]);
      check("ex_vaddr", ex_vaddr, m_vaddr[k]);
    end
    check("csr_we", csr_we, exp_csr);
    if (exp_csr) begin
      check("csr_addr", csr_addr, m_csr_addr);
      check("csr_wdata", csr_wdata, m_csr_wdata);
      check("csr_wmask", csr_wmask, m_csr_wmask);
    end
    check("retire_cnt", retire_cnt, m_retire);
    check("dbg_we", debug_wb_rf_we, m_dbg_v ? 4'hF : 4'h0);
    if (m_dbg_v) begin
      check("dbg_pc", debug_wb_pc, m_dbg.pc);
      check("dbg_wnum", debug_wb_rf_wnum, m_dbg.wnum);
      check("dbg_wdata", debug_wb_rf_wdata, m_dbg.wdata);
    end
    @(posedge clk);
    if (!rstn) begin
      reset_model();
    end else begin
      m_dbg_v = (m_fifo.size() > 0);
      if (m_dbg_v) m_dbg = m_fifo.pop_front();
      for (int i = 0; i < NLANE; i++)
        if (exp_we[i]) m_fifo.push_back('{pc: m_pc[i], wnum: m_dest[i], wdata: m_res[i]});
      if (commit) m_retire = (m_retire + nret) % CNT_MOD;
      last_load = load && !flush;
      if (flush) m_wv = 1'b0;
      else if (load) begin
        m_wv = 1'b1;
        m_v = mw_if.mw_lane_v; m_we = mw_if.mw_gr_we; m_ex = mw_if.mw_ex; m_esub = mw_if.mw_esubcode;
        for (int i = 0; i < NLANE; i++) begin
          m_pc[i] = mw_if.mw_pc[32*i +: 32]; m_res[i] = mw_if.mw_result[32*i +: 32];
          m_vaddr[i] = mw_if.mw_vaddr[32*i +: 32]; m_dest[i] = mw_if.mw_dest[5*i +: 5];
          m_ecode[i] = mw_if.mw_ecode[8*i +: 8];
        end
        m_csr_we = mw_if.mw_csr_we; m_csr_addr = mw_if.mw_csr_addr;
        m_csr_wmask = mw_if.mw_csr_wmask; m_csr_wdata = mw_if.mw_csr_wdata;
      end else if (commit) m_wv = 1'b0;
    end
    #1;
  endtask

  task automatic drain(input int n);
    mw_if.mw_valid = 1'b0; flush = 1'b0;
    repeat (n) cycle();
  endtask

  initial begin
    logic [31:0] pc;
    int guard;
    mw_if.mw_valid = 1'b0;
    for (int i = 0; i < NLANE; i++) set_lane(i, 1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 8'h0);
    set_csr(1'b0, 14'h0, 32'h0, 32'h0);
    reset_model();

    // 1: reset state
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    check("rst_allowin", mw_if.w_allowin, 1'b1);
    check("rst_rf_we", rf_we, 2'b00);
    check("rst_ex_valid", ex_valid, 1'b0);
    check("rst_csr_we", csr_we, 1'b0);
    check("rst_dbg_we", debug_wb_rf_we, 4'h0);
    check("rst_retire", retire_cnt, 0);
    check("rst_rf_waddr", rf_waddr, 0);
    check("rst_rf_wdata", rf_wdata, 0);
    check("rst_ex_pc", ex_pc, 0);
    check("rst_dbg_pc", debug_wb_pc, 0);
    check("rst_csr_addr", csr_addr, 0);

    // 2: two clean lanes plus a lane-0 CSR write
    set_lane(0, 1'b1, 32'h1c00_0000, 1'b1, 5'd4, 32'h11, 1'b0, 8'h0);
    set_lane(1, 1'b1, 32'h1c00_0004, 1'b1, 5'd5, 32'h22, 1'b0, 8'h0);
    set_csr(1'b1, 14'h0006, 32'hffff_ffff, 32'h1234_5678);
    mw_if.mw_valid = 1'b1;
    cycle();
    mw_if.mw_valid = 1'b0;
    check("t2_rf_we", rf_we, 2'b11);
    check("t2_csr_we", csr_we, 1'b1);
    cycle();
    check("t2_retire", retire_cnt, 2);
    drain(4);

    // 3: oldest-lane exception suppresses everything; a lane-1 exception keeps lane 0
    set_lane(0, 1'b1, 32'h1c00_0008, 1'b1, 5'd3, 32'h33, 1'b1, ECODE_SYS);
    set_lane(1, 1'b1, 32'h1c00_000c, 1'b1, 5'd6, 32'h44, 1'b0, 8'h0);
    mw_if.mw_valid = 1'b1;
    cycle();
    mw_if.mw_valid = 1'b0;
    check("t3a_ex_valid", ex_valid, 1'b1);
    check("t3a_ex_pc", ex_pc, 32'h1c00_0008);
    check("t3a_ex_ecode", ex_ecode, ECODE_SYS);
    check("t3a_rf_we", rf_we, 2'b00);
    check("t3a_csr_we", csr_we, 1'b0);
    cycle();
    check("t3a_retire", retire_cnt, 2);
    set_lane(0, 1'b1, 32'h1c00_0010, 1'b1, 5'd6, 32'h55, 1'b0, 8'h0);
    set_lane(1, 1'b1, 32'h1c00_0014, 1'b1, 5'd7, 32'h66, 1'b1, ECODE_ALE);
    set_csr(1'b0, 14'h0, 32'h0, 32'h0);
    mw_if.mw_valid = 1'b1;
    cycle();
    mw_if.mw_valid = 1'b0;
    check("t3b_rf_we", rf_we, 2'b01);
    check("t3b_ex_pc", ex_pc, 32'h1c00_0014);
    check("t3b_ex_ecode", ex_ecode, ECODE_ALE);
    cycle();
    check("t3b_retire", retire_cnt, 3);
    drain(4);

    // 4: back-to-back full bundles until the trace FIFO backs up
    pc = 32'h1c00_1000;
    guard = 0;
    mw_if.mw_valid = 1'b1;
    while (m_fifo.size() < DEPTH - 1 && guard < 40) begin
      set_lane(0, 1'b1, pc, 1'b1, 5'd8, pc, 1'b0, 8'h0);
      set_lane(1, 1'b1, pc + 32'd4, 1'b1, 5'd9, pc + 32'd4, 1'b0, 8'h0);
      cycle();
      if (last_load) pc = pc + 32'd8;
      guard++;
    end
    set_lane(0, 1'b1, pc, 1'b1, 5'd8, pc, 1'b0, 8'h0);
    set_lane(1, 1'b1, pc + 32'd4, 1'b1, 5'd9, pc + 32'd4, 1'b0, 8'h0);
    check("t4_allowin_drop", mw_if.w_allowin, 1'b0);

    // 5: flush against a held bundle and a same-cycle load
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    mw_if.mw_valid = 1'b0;
    check("t5_allowin", mw_if.w_allowin, 1'b1);
    check("t5_rf_we", rf_we, 2'b00);
    drain(12);
    check("t5_drained", debug_wb_rf_we, 4'h0);

    // random traffic with a reset in the middle
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NLANE; i++)
        set_lane(i, $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1) != 0,
                 5'($urandom_range(0, 31)), $urandom, $urandom_range(0, 7) == 0, 8'($urandom_range(0, 63)));
      set_csr($urandom_range(0, 1) != 0, 14'($urandom_range(0, 16383)), $urandom, $urandom);
      mw_if.mw_valid = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 15) == 0;
      rstn = !(n == 200 || n == 201);
      cycle();
    end
    rstn = 1'b1;
    set_csr(1'b0, 14'h0, 32'h0, 32'h0);
    drain(12);

    // 6: walk the counter to its top, then a same-register double write wraps it
    pc = 32'h1c00_2000;
    guard = 0;
    while (!(m_retire == CNT_MOD - 1 && !m_wv) && guard < 600) begin
      set_lane(0, 1'b1, pc, 1'b1, 5'd1, pc, 1'b0, 8'h0);
      set_lane(1, 1'b0, pc + 32'd4, 1'b0, 5'd2, 32'h0, 1'b0, 8'h0);
      mw_if.mw_valid = (m_retire + int'(m_wv)) < CNT_MOD - 1;
      cycle();
      pc = pc + 32'd8;
      guard++;
    end
    mw_if.mw_valid = 1'b0;
    cycle();
    check("t6_pre_retire", retire_cnt, CNT_MOD - 1);
    set_lane(0, 1'b1, 32'h1c00_3000, 1'b1, 5'd7, 32'hA, 1'b0, 8'h0);
    set_lane(1, 1'b1, 32'h1c00_3004, 1'b1, 5'd7, 32'hB, 1'b0, 8'h0);
    mw_if.mw_valid = 1'b1;
    cycle();
    mw_if.mw_valid = 1'b0;
    check("t6_rf_we", rf_we, 2'b11);
    check("t6_rf_waddr", rf_waddr, {5'd7, 5'd7});
    cycle();
    check("t6_retire_wrap", retire_cnt, 1);
    cycle();
    check("t6_trace_first", debug_wb_rf_wdata, 32'hA);
    cycle();
    check("t6_trace_second", debug_wb_rf_wdata, 32'hB);
    drain(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
